// File: rtl/friscv_scfifo_ctrl.sv
// Single-clock first-word-fall-through FIFO: pointer/flag control around a small RAM.
// Latency: a pushed word is visible on data_out one cycle after the push edge; pull pops at the edge.
// Backpressure: push while full is dropped (overflow pulse), pull while empty is ignored (underflow pulse).

module friscv_scfifo_ram
  #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
  )(
    input  logic                  aclk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] addr_out,
    output logic [DATA_WIDTH-1:0] data_out
  );

  // Storage is deliberately never reset; stale entries are unreachable once pointers clear.
  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

  // Synchronous write port.
  always_ff @(posedge aclk) begin
    if (wr_en) mem[addr_in] <= data_in;
  end

  // Asynchronous read port gives the fall-through head.
  assign data_out = mem[addr_out];

endmodule

module friscv_scfifo_ctrl
  #(
    parameter int ADDR_WIDTH    = 8,
    parameter int DATA_WIDTH    = 8,
    parameter int AFULL_THRESH  = 2**ADDR_WIDTH-1,
    parameter int AEMPTY_THRESH = 1
  )(
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  srst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  full,
    output logic                  afull,
    input  logic                  pull,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  empty,
    output logic                  aempty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
  );

  localparam logic [ADDR_WIDTH:0] PTR_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0] AFULL_LVL  = AFULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = AEMPTY_THRESH[ADDR_WIDTH:0];

  // Extra MSB on each pointer is the wrap bit that tells full from empty.
  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic                wr_acc;
  logic                rd_acc;
  logic                ram_wr_en;

  // Acceptance decisions use the flags as they stand before the edge.
  assign wr_acc    = push & ~full;
  assign rd_acc    = pull & ~empty;
  // A clear in the same cycle wins over the write.
  assign ram_wr_en = wr_acc & ~srst;

  // Pointer and error-pulse registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (srst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      overflow  <= push & full;
      underflow <= pull & empty;
    end
  end

  // Status derived purely from registered pointers, no path from push/pull.
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]) &&
                  (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);
  assign count  = wr_ptr - rd_ptr;
  assign afull  = (count >= AFULL_LVL);
  assign aempty = (count <= AEMPTY_LVL);

  friscv_scfifo_ram
    #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
      .aclk     (aclk),
      .wr_en    (ram_wr_en),
      .addr_in  (wr_ptr[ADDR_WIDTH-1:0]),
      .data_in  (data_in),
      .addr_out (rd_ptr[ADDR_WIDTH-1:0]),
      .data_out (data_out)
    );

endmodule
